// File: rtl/div_exec_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with CDB slot handshake.
// Optional `DIV_EARLY_OUT_EN`: divide-by-zero and signed-overflow ops skip the CALC phase.
module div_exec_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned CDB_LAT = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_issue_valid,
  output logic             o_issue_ready,
  input  logic [1:0]       i_issue_op,
  input  logic [XLEN-1:0]  i_rs1_data,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic [TAG_W-1:0] i_rob_tag,
  output logic             o_exec_busy,
  output logic             o_ready_div,
  input  logic             i_issue_div_done,
  output logic             o_cdb_valid,
  output logic [TAG_W-1:0] o_cdb_tag,
  output logic [XLEN-1:0]  o_cdb_data
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam int unsigned DW = $clog2(CDB_LAT + 1);

  typedef enum logic [1:0] {IDLE, CALC, WAIT_GNT, DRAIN} state_e;

  state_e            state_q;
  logic              rem_op_q;
  logic [TAG_W-1:0]  tag_q;
  logic              qneg_q;
  logic              rneg_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   dvs_q;
  logic [XLEN:0]     rem_q;
  logic [CW-1:0]     cnt_q;
  logic [DW-1:0]     drain_q;
  logic [XLEN-1:0]   res_q;

  logic              is_signed;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic              div_zero;
  logic [XLEN+1:0]   rem_sh;
  logic [XLEN+1:0]   diff;
  logic              ge;
  logic [XLEN:0]     rem_d;
  logic [XLEN-1:0]   quo_d;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;
  logic [XLEN-1:0]   res_d;

  always_comb begin
    is_signed = ~i_issue_op[0];
    a_neg     = is_signed & i_rs1_data[XLEN-1];
    b_neg     = is_signed & i_rs2_data[XLEN-1];
    a_abs     = a_neg ? (~i_rs1_data + 1'b1) : i_rs1_data;
    b_abs     = b_neg ? (~i_rs2_data + 1'b1) : i_rs2_data;
    div_zero  = (i_rs2_data == '0);
  end

  // Restoring step; remainder never exceeds XLEN bits, the extra bits only carry the borrow.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {2'b00, dvs_q};
    ge     = ~diff[XLEN+1];
    rem_d  = ge ? diff[XLEN:0] : rem_sh[XLEN:0];
    quo_d  = {quo_q[XLEN-2:0], ge};
    q_fix  = qneg_q ? (~quo_d + 1'b1) : quo_d;
    r_fix  = rneg_q ? (~rem_d[XLEN-1:0] + 1'b1) : rem_d[XLEN-1:0];
    res_d  = rem_op_q ? r_fix : q_fix;
  end

`ifdef DIV_EARLY_OUT_EN
  logic            ovf;
  logic [XLEN-1:0] spec_res;
  always_comb begin
    ovf      = is_signed & (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (i_rs2_data == '1);
    spec_res = div_zero ? (i_issue_op[1] ? i_rs1_data : '1)
                        : (i_issue_op[1] ? '0 : i_rs1_data);
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      rem_op_q <= 1'b0;
      tag_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      drain_q  <= '0;
      res_q    <= '0;
    end else if (i_flush) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_issue_valid) begin
            rem_op_q <= i_issue_op[1];
            tag_q    <= i_rob_tag;
            // Divide-by-zero keeps the all-ones quotient unsigned; the remainder path restores the dividend.
            qneg_q   <= (a_neg ^ b_neg) & ~div_zero;
            rneg_q   <= a_neg;
            quo_q    <= a_abs;
            dvs_q    <= b_abs;
            rem_q    <= '0;
            cnt_q    <= CW'(XLEN - 1);
`ifdef DIV_EARLY_OUT_EN
            if (div_zero | ovf) begin
              res_q   <= spec_res;
              state_q <= WAIT_GNT;
            end else begin
              state_q <= CALC;
            end
`else
            state_q  <= CALC;
`endif
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            res_q   <= res_d;
            state_q <= WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (i_issue_div_done) begin
            drain_q <= DW'(CDB_LAT - 1);
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_q == '0) state_q <= IDLE;
          else               drain_q <= drain_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_issue_ready = (state_q == IDLE);
    o_exec_busy   = (state_q == CALC);
    o_ready_div   = (state_q == WAIT_GNT);
    o_cdb_valid   = (state_q == DRAIN) && (drain_q == '0) && !i_flush;
    o_cdb_tag     = o_cdb_valid ? tag_q : '0;
    o_cdb_data    = o_cdb_valid ? res_q : '0;
  end

endmodule

// File: tb/tb_div_exec_unit.sv
// Bench for div_exec_unit: timestamp-based behavioural model checked every cycle plus directed literal results.
module tb_div_exec_unit;
  localparam int XLEN = 32;
  localparam int TAG_W = 6;
  localparam int CDB_LAT = 7;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             iv = 1'b0;
  logic             done = 1'b0;
  logic [1:0]       op = '0;
  logic [XLEN-1:0]  a = '0;
  logic [XLEN-1:0]  b = '0;
  logic [TAG_W-1:0] tag = '0;

  logic             issue_ready, exec_busy, ready_div, cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .CDB_LAT(CDB_LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_issue_valid(iv), .o_issue_ready(issue_ready), .i_issue_op(op),
    .i_rs1_data(a), .i_rs2_data(b), .i_rob_tag(tag),
    .o_exec_busy(exec_busy), .o_ready_div(ready_div), .i_issue_div_done(done),
    .o_cdb_valid(cdb_valid), .o_cdb_tag(cdb_tag), .o_cdb_data(cdb_data)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      return o[1] ? 32'(sx % sy) : 32'(sx / sy);
    end
    return o[1] ? (x % y) : (x / y);
  endfunction

  function automatic int calc_len(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef DIV_EARLY_OUT_EN
    if (y == 32'd0) return 0;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
`endif
    return XLEN;
  endfunction

  // Model: one op in flight, described by its accept cycle, compute length and grant cycle.
  int               cyc = 0;
  bit               m_alive = 1'b0;
  int               m_acc = 0;
  int               m_len = 0;
  int               m_gnt = -1;
  logic [31:0]      m_data = '0;
  logic [TAG_W-1:0] m_tag = '0;

  always @(posedge clk) begin
    if (rst || flush) begin
      m_alive = 1'b0;
    end else if (!m_alive) begin
      if (iv) begin
        m_alive = 1'b1;
        m_acc   = cyc;
        m_len   = calc_len(op, a, b);
        m_gnt   = -1;
        m_data  = ref_res(op, a, b);
        m_tag   = tag;
      end
    end else if (m_gnt < 0) begin
      if (done && cyc > m_acc + m_len) m_gnt = cyc;
    end else if (cyc == m_gnt + CDB_LAT) begin
      m_alive = 1'b0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic e_ir, e_busy, e_rdy, e_v;
    if (rst || !m_alive) begin
      e_ir = !rst ? 1'b1 : 1'b1;
      e_busy = 1'b0; e_rdy = 1'b0; e_v = 1'b0;
    end else begin
      e_ir   = 1'b0;
      e_busy = (cyc > m_acc) && (cyc <= m_acc + m_len);
      e_rdy  = (cyc > m_acc + m_len) && (m_gnt < 0);
      e_v    = (m_gnt >= 0) && (cyc == m_gnt + CDB_LAT) && !flush;
    end
    chk("issue_ready", 32'(issue_ready), 32'(e_ir));
    chk("exec_busy", 32'(exec_busy), 32'(e_busy));
    chk("ready_div", 32'(ready_div), 32'(e_rdy));
    chk("cdb_valid", 32'(cdb_valid), 32'(e_v));
    chk("cdb_tag", 32'(cdb_tag), e_v ? 32'(m_tag) : 32'd0);
    chk("cdb_data", cdb_data, e_v ? m_data : 32'd0);
  end

  task automatic issue_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [TAG_W-1:0] t);
    @(posedge clk); #1;
    iv = 1'b1; op = o; a = x; b = y; tag = t;
    @(posedge clk); #1;
    iv = 1'b0;
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_div) begin ok = 1'b1; break; end
    end
    chk("ready_timeout", 32'(ok), 32'd1);
  endtask

  task automatic grant_and_check(input int delay, input logic [TAG_W-1:0] et, input logic [31:0] ed, input string nm);
    int n = 0;
    logic [31:0] gd = '0;
    logic [TAG_W-1:0] gt = '0;
    wait_ready();
    repeat (delay) @(posedge clk);
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (cdb_valid) begin n = i; gd = cdb_data; gt = cdb_tag; break; end
    end
    chk({nm, "_lat"}, n, CDB_LAT);
    chk({nm, "_tag"}, 32'(gt), 32'(et));
    chk({nm, "_data"}, gd, ed);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [TAG_W-1:0] t, input logic [31:0] ed, input string nm);
    issue_op(o, x, y, t);
    grant_and_check(0, t, ed, nm);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    run(OP_DIVU, 32'd100, 32'd7, 6'd5, 32'd14, "divu");
    run(OP_REMU, 32'd100, 32'd7, 6'd5, 32'd2, "remu");
    run(OP_DIV, 32'hFFFF_FF9C, 32'd7, 6'd12, 32'hFFFF_FFF2, "div_neg_a");
    run(OP_REM, 32'hFFFF_FF9C, 32'd7, 6'd13, 32'hFFFF_FFFE, "rem_neg_a");
    run(OP_DIV, 32'd100, 32'hFFFF_FFF9, 6'd14, 32'hFFFF_FFF2, "div_neg_b");
    run(OP_REM, 32'd100, 32'hFFFF_FFF9, 6'd15, 32'd2, "rem_neg_b");
    run(OP_DIV, 32'h1234_5678, 32'd0, 6'd20, 32'hFFFF_FFFF, "div_by0");
    run(OP_REMU, 32'h1234_5678, 32'd0, 6'd21, 32'h1234_5678, "remu_by0");
    run(OP_REM, 32'hFFFF_FF9C, 32'd0, 6'd22, 32'hFFFF_FF9C, "rem_neg_by0");
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd23, 32'h8000_0000, "div_ovf");
    run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 6'd24, 32'd0, "rem_ovf");
    run(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 6'd63, 32'hFFFF_FFFF, "divu_max");

    // Issue held valid across a whole op; spurious grant during CALC; late grant.
    @(posedge clk); #1;
    iv = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7; tag = 6'd5;
    @(posedge clk); #1;
    op = OP_DIV; a = 32'hFFFF_FF9C; b = 32'd7; tag = 6'd9;
    repeat (5) @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    grant_and_check(10, 6'd5, 32'd14, "b2b_first");
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (issue_ready) begin seen = 1'b1; break; end
      end
      chk("b2b_idle_timeout", 32'(seen), 32'd1);
    end
    @(posedge clk); #1 iv = 1'b0;
    grant_and_check(0, 6'd9, 32'hFFFF_FFF2, "b2b_second");

    // Flush mid-CALC, then a fresh op the next cycle.
    issue_op(OP_DIVU, 32'd1000, 32'd3, 6'd7);
    repeat (9) @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; iv = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3; tag = 6'd3;
    @(posedge clk); #1 iv = 1'b0;
    grant_and_check(0, 6'd3, 32'd3, "post_flush");

    // Flush wins over accept in the same cycle.
    @(posedge clk); #1;
    flush = 1'b1; iv = 1'b1; op = OP_DIVU; a = 32'd8; b = 32'd2; tag = 6'd1;
    @(posedge clk); #1;
    flush = 1'b0; iv = 1'b0;
    @(negedge clk);
    chk("flush_vs_accept", 32'(issue_ready), 32'd1);

    // Flush exactly in the broadcast cycle.
    issue_op(OP_REMU, 32'd100, 32'd7, 6'd11);
    wait_ready();
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_drain0_valid", 32'(cdb_valid), 32'd0);
    @(posedge clk); #1 flush = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of DRAIN.
    issue_op(OP_DIVU, 32'd100, 32'd7, 6'd2);
    wait_ready();
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_issue_ready", 32'(issue_ready), 32'd1);
    chk("arst_ready_div", 32'(ready_div), 32'd0);
    chk("arst_busy", 32'(exec_busy), 32'd0);
    chk("arst_cdb_valid", 32'(cdb_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);

    run(OP_DIVU, 32'd9, 32'd3, 6'd4, 32'd3, "after_rst");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
